// File: rtl/multi_channel_clock_divider_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package led_clkdiv_pkg;

  // Output shaping per channel: square wave or single-cycle pulse.
  typedef enum logic {
    CLKDIV_TOGGLE = 1'b0,
    CLKDIV_PULSE  = 1'b1
  } clkdiv_mode_e;

  // Active divisor loaded into every channel by reset.
  localparam int unsigned CLKDIV_RESET_DIV = 32'd1;

endpackage

// File: rtl/multi_channel_clock_divider_if.sv
// Global control bundle: block reset plus a synchronous soft reset.
interface global_if;
  logic reset;
  logic srst;

  modport master (output reset, output srst);
  modport slave  (input reset, input srst);
endinterface

// File: rtl/multi_channel_clock_divider_channel.sv
// One divider channel: counter, active and pending settings, registered outputs.
module clkdiv_channel
  import led_clkdiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             srst,
  input  logic             enable,
  input  logic             sync_restart,
  input  logic             capture,
  input  logic [WIDTH-1:0] div_in,
  input  clkdiv_mode_e     mode_in,
  output logic             pend_next,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(CLKDIV_RESET_DIV);

  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] div_r, div_s;
  logic [WIDTH-1:0] pdiv_r, pdiv_s;
  clkdiv_mode_e     mode_r, mode_s;
  clkdiv_mode_e     pmode_r, pmode_s;
  logic             pvalid_r, pvalid_s;
  logic             clk_out_r, clk_out_s;
  logic             tick_r, tick_s;
  logic [WIDTH-1:0] eff_div_s;
  logic [WIDTH-1:0] last_s;
  logic             wrap_s;

  // A zero divisor behaves as divide-by-one.
  assign eff_div_s = (div_r == {WIDTH{1'b0}}) ? ONE : div_r;
  assign last_s    = eff_div_s - ONE;
  assign wrap_s    = enable && (cnt_r == last_s);

  // Next-state: restart, disabled hold, or normal counting with deferred apply.
  always_comb begin
    cnt_s     = cnt_r;
    div_s     = div_r;
    mode_s    = mode_r;
    pdiv_s    = pdiv_r;
    pmode_s   = pmode_r;
    pvalid_s  = pvalid_r;
    clk_out_s = clk_out_r;
    tick_s    = 1'b0;
    if (sync_restart) begin
      cnt_s     = {WIDTH{1'b0}};
      clk_out_s = 1'b0;
      tick_s    = 1'b0;
      if (capture) begin
        div_s    = div_in;
        mode_s   = mode_in;
        pvalid_s = 1'b0;
      end else if (pvalid_r) begin
        div_s    = pdiv_r;
        mode_s   = pmode_r;
        pvalid_s = 1'b0;
      end else begin
        pvalid_s = 1'b0;
      end
    end else if (!enable) begin
      cnt_s     = {WIDTH{1'b0}};
      clk_out_s = 1'b0;
      tick_s    = 1'b0;
      if (capture) begin
        pdiv_s   = div_in;
        pmode_s  = mode_in;
        pvalid_s = 1'b1;
      end else if (pvalid_r) begin
        div_s    = pdiv_r;
        mode_s   = pmode_r;
        pvalid_s = 1'b0;
      end else begin
        pvalid_s = 1'b0;
      end
    end else begin
      tick_s = wrap_s;
      if (wrap_s) begin
        cnt_s     = {WIDTH{1'b0}};
        clk_out_s = (mode_r == CLKDIV_PULSE) ? 1'b1 : ~clk_out_r;
      end else begin
        cnt_s     = cnt_r + ONE;
        clk_out_s = (mode_r == CLKDIV_PULSE) ? 1'b0 : clk_out_r;
      end
      // Pending was written on an earlier edge, so a wrap on the capture edge never applies.
      if (capture) begin
        pdiv_s   = div_in;
        pmode_s  = mode_in;
        pvalid_s = 1'b1;
      end else if (pvalid_r && wrap_s) begin
        div_s    = pdiv_r;
        mode_s   = pmode_r;
        pvalid_s = 1'b0;
      end else begin
        pvalid_s = pvalid_r;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_r     <= {WIDTH{1'b0}};
      div_r     <= RESET_DIV;
      mode_r    <= CLKDIV_TOGGLE;
      pdiv_r    <= {WIDTH{1'b0}};
      pmode_r   <= CLKDIV_TOGGLE;
      pvalid_r  <= 1'b0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
    end else if (srst) begin
      cnt_r     <= {WIDTH{1'b0}};
      div_r     <= RESET_DIV;
      mode_r    <= CLKDIV_TOGGLE;
      pdiv_r    <= {WIDTH{1'b0}};
      pmode_r   <= CLKDIV_TOGGLE;
      pvalid_r  <= 1'b0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      div_r     <= div_s;
      mode_r    <= mode_s;
      pdiv_r    <= pdiv_s;
      pmode_r   <= pmode_s;
      pvalid_r  <= pvalid_s;
      clk_out_r <= clk_out_s;
      tick_r    <= tick_s;
    end
  end

  assign pend_next = pvalid_s;
  assign clk_out   = clk_out_r;
  assign tick      = tick_r;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// Multi-channel clock divider top: load/ack/busy handshake and channel array.
module multi_channel_clock_divider
  import led_clkdiv_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                            clk_in,
  global_if.slave                         glb,
  input  logic [CHANNELS-1:0]             ch_enable,
  input  logic [CHANNELS-1:0][WIDTH-1:0]  divisor,
  input  logic [CHANNELS-1:0]             mode,
  input  logic                            load,
  input  logic                            sync_restart,
  output logic                            load_ack,
  output logic                            load_busy,
  output logic [CHANNELS-1:0]             clk_out,
  output logic [CHANNELS-1:0]             tick
);

  logic                rst_s;
  logic                srst_s;
  logic                accept_s;
  logic [CHANNELS-1:0] pend_next_s;
  logic                load_ack_r;
  logic                load_busy_r;

  assign rst_s    = glb.reset;
  assign srst_s   = glb.srst;
  // A load is only taken when no earlier setting is still waiting to apply.
  assign accept_s = load && !load_busy_r;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clkdiv_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk_in       (clk_in),
      .rst          (rst_s),
      .srst         (srst_s),
      .enable       (ch_enable[i]),
      .sync_restart (sync_restart),
      .capture      (accept_s),
      .div_in       (divisor[i]),
      .mode_in      (clkdiv_mode_e'(mode[i])),
      .pend_next    (pend_next_s[i]),
      .clk_out      (clk_out[i]),
      .tick         (tick[i])
    );
  end

  // Ack pulse and busy flag; busy mirrors whether any channel still holds a pending setting.
  always_ff @(posedge clk_in or posedge rst_s) begin
    if (rst_s) begin
      load_ack_r  <= 1'b0;
      load_busy_r <= 1'b0;
    end else if (srst_s) begin
      load_ack_r  <= 1'b0;
      load_busy_r <= 1'b0;
    end else begin
      load_ack_r  <= accept_s;
      load_busy_r <= |pend_next_s;
    end
  end

  assign load_ack  = load_ack_r;
  assign load_busy = load_busy_r;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed self-checking bench for multi_channel_clock_divider (4 channels, 8-bit).
module tb_multi_channel_clock_divider;

  logic            clk_in;
  logic [3:0]      ch_enable;
  logic [3:0][7:0] divisor;
  logic [3:0]      mode;
  logic            load;
  logic            sync_restart;
  logic            load_ack;
  logic            load_busy;
  logic [3:0]      clk_out;
  logic [3:0]      tick;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_clk_a  [0:8];
  logic [3:0] exp_tick_a [0:8];
  logic [3:0] exp_clk_b  [0:4];
  logic [3:0] exp_tick_b [0:4];

  global_if glb_if ();

  multi_channel_clock_divider #(
    .CHANNELS (4),
    .WIDTH    (8)
  ) dut (
    .clk_in       (clk_in),
    .glb          (glb_if),
    .ch_enable    (ch_enable),
    .divisor      (divisor),
    .mode         (mode),
    .load         (load),
    .sync_restart (sync_restart),
    .load_ack     (load_ack),
    .load_busy    (load_busy),
    .clk_out      (clk_out),
    .tick         (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_clk_a  = '{4'hC, 4'h0, 4'hD, 4'h3, 4'hD, 4'h0, 4'hC, 4'h2, 4'hD};
    exp_tick_a = '{4'hC, 4'hC, 4'hD, 4'hE, 4'hC, 4'hD, 4'hC, 4'hE, 4'hD};
    exp_clk_b  = '{4'h2, 4'hC, 4'h0, 4'hD, 4'h3};
    exp_tick_b = '{4'hF, 4'hC, 4'hC, 4'hD, 4'hE};

    // Reset state
    glb_if.reset = 1'b1;
    glb_if.srst  = 1'b0;
    ch_enable    = 4'h0;
    divisor      = {8'd0, 8'd0, 8'd0, 8'd0};
    mode         = 4'h0;
    load         = 1'b0;
    sync_restart = 1'b0;
    step();
    step();
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_ack", 32'(load_ack), 32'h0);
    chk("rst_busy", 32'(load_busy), 32'h0);
    glb_if.reset = 1'b0;
    ch_enable    = 4'hF;

    // Default div 1 TOGGLE on all channels
    step();
    chk("div1_clk_e1", 32'(clk_out), 32'hF);
    chk("div1_tick_e1", 32'(tick), 32'hF);
    step();
    chk("div1_clk_e2", 32'(clk_out), 32'h0);
    chk("div1_tick_e2", 32'(tick), 32'hF);

    // Load ch0=3 TOGGLE, ch1=4 PULSE, ch2/ch3=1 TOGGLE
    divisor = {8'd1, 8'd1, 8'd4, 8'd3};
    mode    = 4'b0010;
    load    = 1'b1;
    step();
    chk("load1_ack", 32'(load_ack), 32'h1);
    chk("load1_busy", 32'(load_busy), 32'h1);
    load = 1'b0;
    step();
    chk("load1_ack_drop", 32'(load_ack), 32'h0);
    chk("load1_busy_drop", 32'(load_busy), 32'h0);
    // Port changes without load must be ignored
    divisor = {8'd9, 8'd9, 8'd9, 8'd9};
    mode    = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("run1_clk_%0d", k), 32'(clk_out), 32'(exp_clk_a[k]));
      chk($sformatf("run1_tick_%0d", k), 32'(tick), 32'(exp_tick_a[k]));
    end

    // Divisor 0 on ch2; second load while busy is ignored
    divisor = {8'd1, 8'd0, 8'd4, 8'd3};
    mode    = 4'b0010;
    load    = 1'b1;
    step();
    chk("load2_ack", 32'(load_ack), 32'h1);
    chk("load2_busy", 32'(load_busy), 32'h1);
    divisor = {8'd7, 8'd7, 8'd7, 8'd7};
    step();
    chk("load3_noack", 32'(load_ack), 32'h0);
    chk("load3_busy", 32'(load_busy), 32'h1);
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) chk("load2_busy_drop", 32'(load_busy), 32'h0);
      chk($sformatf("run2_clk_%0d", k), 32'(clk_out), 32'(exp_clk_b[k]));
      chk($sformatf("run2_tick_%0d", k), 32'(tick), 32'(exp_tick_b[k]));
    end

    // sync_restart together with a load: all channels div 5 TOGGLE
    divisor      = {8'd5, 8'd5, 8'd5, 8'd5};
    mode         = 4'h0;
    load         = 1'b1;
    sync_restart = 1'b1;
    step();
    chk("sync_clk", 32'(clk_out), 32'h0);
    chk("sync_tick", 32'(tick), 32'h0);
    chk("sync_ack", 32'(load_ack), 32'h1);
    load         = 1'b0;
    sync_restart = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("sync_wait_tick_%0d", k), 32'(tick), 32'h0);
    end
    step();
    chk("sync_tick_align", 32'(tick), 32'hF);
    chk("sync_clk_align", 32'(clk_out), 32'hF);

    // Load ch0=10 while running at 5: current count completes first
    divisor = {8'd5, 8'd5, 8'd5, 8'd10};
    load    = 1'b1;
    step();
    chk("load4_ack", 32'(load_ack), 32'h1);
    chk("load4_busy", 32'(load_busy), 32'h1);
    load = 1'b0;
    step();
    step();
    step();
    chk("load4_busy_hold", 32'(load_busy), 32'h1);
    step();
    chk("load4_busy_fall", 32'(load_busy), 32'h0);
    chk("load4_tick_apply", 32'(tick), 32'hF);
    chk("load4_clk_apply", 32'(clk_out), 32'h0);
    repeat (5) step();
    chk("div10_tick_mid", 32'(tick), 32'hE);
    chk("div10_clk_mid", 32'(clk_out), 32'hE);
    repeat (5) step();
    chk("div10_tick_end", 32'(tick), 32'hF);
    chk("div10_clk_end", 32'(clk_out), 32'h1);

    // Reset mid-busy, then three disabled cycles with a load applied while disabled
    divisor = {8'd3, 8'd3, 8'd3, 8'd3};
    load    = 1'b1;
    step();
    chk("load5_busy", 32'(load_busy), 32'h1);
    load = 1'b0;
    #2;
    glb_if.reset = 1'b1;
    ch_enable    = 4'h0;
    #1;
    chk("rst2_clk", 32'(clk_out), 32'h0);
    chk("rst2_tick", 32'(tick), 32'h0);
    chk("rst2_ack", 32'(load_ack), 32'h0);
    chk("rst2_busy", 32'(load_busy), 32'h0);
    step();
    glb_if.reset = 1'b0;
    step();
    chk("dis_clk_0", 32'(clk_out), 32'h0);
    chk("dis_busy_0", 32'(load_busy), 32'h0);
    divisor = {8'd1, 8'd1, 8'd1, 8'd2};
    load    = 1'b1;
    step();
    chk("dis_ack", 32'(load_ack), 32'h1);
    chk("dis_busy_1", 32'(load_busy), 32'h1);
    chk("dis_clk_1", 32'(clk_out), 32'h0);
    load = 1'b0;
    step();
    chk("dis_busy_2", 32'(load_busy), 32'h0);
    chk("dis_clk_2", 32'(clk_out), 32'h0);
    chk("dis_tick_2", 32'(tick), 32'h0);
    ch_enable = 4'hF;
    step();
    chk("reen_tick_1", 32'(tick), 32'hE);
    chk("reen_clk_1", 32'(clk_out), 32'hE);
    step();
    chk("reen_tick_2", 32'(tick), 32'hF);
    chk("reen_clk_2", 32'(clk_out), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_channel_clock_divider.md
MULTI_CHANNEL_CLOCK_DIVIDER -- requirements
Module: multi_channel_clock_divider

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter WIDTH, default 8: divisor and counter width in bits, 2..16.
REQ-003 Port clk_in, input, 1: the block's only clock; all state SHALL change on posedge clk_in only.
REQ-004 Port glb, global_if, -: glb.reset is the block reset, asynchronous and active-high.
REQ-005 Port ch_enable, input, [CHANNELS]: per-channel run enable.
REQ-006 Port divisor, input, [CHANNELS][WIDTH]: requested per-channel divisor, sampled only on an accepted load.
REQ-007 Port mode, input, [CHANNELS]: requested per-channel mode, 0 = TOGGLE, 1 = PULSE, sampled only on an accepted load.
REQ-008 Port load, input, 1: one-cycle request to capture divisor and mode for all channels.
REQ-009 Port sync_restart, input, 1: one-cycle request to phase-align all channels.
REQ-010 Port load_ack, output, 1: one-cycle pulse confirming an accepted load.
REQ-011 Port load_busy, output, 1: high while any captured setting is not yet applied.
REQ-012 Port clk_out, output, [CHANNELS]: registered divided outputs.
REQ-013 Port tick, output, [CHANNELS]: registered one-cycle terminal-count pulses.

Function
REQ-014 Each channel SHALL hold an active divisor and an active mode; effective divisor = 1 when active divisor is 0, otherwise active divisor.
REQ-015 An enabled channel's counter SHALL count 0..div-1, wrap to 0 at div-1, and assert tick in the cycle after the wrap edge, for exactly one cycle.
REQ-016 TOGGLE mode: clk_out SHALL toggle on each wrap, giving period 2*div cycles at 50% duty.
REQ-017 PULSE mode: clk_out SHALL equal tick, giving one high cycle per div cycles; div = 1 SHALL hold clk_out constantly high.
REQ-018 A load while load_busy = 0 SHALL be accepted: divisor and mode captured into per-channel pending registers, load_ack high the next cycle, and load_busy high from the next cycle.
REQ-019 A load while load_busy = 1 SHALL be ignored, with no ack and no capture.
REQ-020 An enabled channel SHALL apply its pending settings at its first wrap after capture, not at a wrap on the capture edge itself; counting continues from 0 with the new settings.
REQ-021 A disabled channel SHALL apply pending settings on the cycle after capture.
REQ-022 load_busy SHALL fall in the cycle after the last channel applies.
REQ-023 ch_enable low SHALL hold the counter at 0 and force clk_out and tick to 0 from the next cycle.
REQ-024 Re-enabling a channel SHALL restart it from count 0, with the first wrap after div cycles.
REQ-025 sync_restart SHALL clear all counters and force all clk_out and tick to 0 the next cycle, and apply any pending settings immediately.
REQ-026 sync_restart together with an accepted load SHALL capture and apply the new settings on that same edge; load_ack still pulses.
REQ-027 Divisor changes on the input port without load SHALL have no effect.

Reset
REQ-028 On glb.reset: counters = 0, clk_out = 0, tick = 0, active divisor = 1, active mode = TOGGLE, pending cleared, load_ack = 0, load_busy = 0.
REQ-029 Reset mid-period or mid-load SHALL abandon all pending settings; the block resumes on the first clock after release.

Structure
REQ-030 Package led_clkdiv_pkg SHALL hold the mode enum clkdiv_mode_e (CLKDIV_TOGGLE, CLKDIV_PULSE) and the reset-default divisor constant.
REQ-031 Sub-module clkdiv_channel SHALL contain one channel (counter, active/pending registers, outputs) and be generated CHANNELS times; the top level SHALL hold the load/ack/busy logic.

Verification
REQ-032 Reset, then ch_enable=1111 with no load -> all channels run at div = 1 TOGGLE, clk_out toggling every cycle.
REQ-033 Load divisor ch0=3 TOGGLE, ch1=4 PULSE -> ack after 1 cycle; ch0 period 6 (3 high, 3 low); ch1 high 1 of every 4 cycles.
REQ-034 Load divisor=0 on ch2 -> behaves as div 1; second load while busy -> no ack and old pending applied.
REQ-035 Load ch0=10 while running at 5 -> current 5-cycle count completes, then 10-cycle counts, busy falls the cycle after the apply.
REQ-036 sync_restart plus load on the same edge -> all outputs 0 next cycle; all ticks coincide div cycles later with the new values.
REQ-037 Assert glb.reset mid-busy, then drop ch_enable for 3 cycles -> all reset values per REQ-028; disabled channel outputs 0 and restarts from 0.
